// File: rtl/game_pkg.sv
// Shared defaults and types for the score keeper datapath.
package game_pkg;
  localparam int N_ENEMY_DEF    = 8;
  localparam int SCORE_W_DEF    = 14;
  localparam int SCORE_MAX_DEF  = 9999;
  localparam int BCD_DIGITS_DEF = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_e;
endpackage

// File: rtl/score_bin2bcd.sv
// Iterative binary-to-packed-BCD converter (shift-add-3), one bit per cycle.
module score_bin2bcd
  import game_pkg::*;
#(
  parameter int W      = SCORE_W_DEF,
  parameter int DIGITS = BCD_DIGITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        value,
  output logic                idle,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);
  localparam int CW = $clog2(W + 1);

  bcd_state_e              state;
  logic [W-1:0]            bin_sr;
  logic [4*DIGITS-1:0]     dig;
  logic [CW-1:0]           cnt;
  logic [4*DIGITS+W-1:0]   sh;

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] d);
    logic [4*DIGITS-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++)
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign sh   = {add3(dig), bin_sr};
  assign idle = (state == IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bin_sr <= '0;
      dig    <= '0;
      cnt    <= '0;
      bcd    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin_sr <= value;
          dig    <= '0;
          cnt    <= CW'(W - 1);
          state  <= SHIFT;
        end
        SHIFT: begin
          {dig, bin_sr} <= {sh[4*DIGITS+W-2:0], 1'b0};
          cnt           <= cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          bcd   <= dig;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/score_keeper.sv
// Kill-edge score accumulator with wave bonus, saturation, high score and BCD readout.
module score_keeper
  import game_pkg::*;
#(
  parameter int N_ENEMY      = N_ENEMY_DEF,
  parameter int SCORE_W      = SCORE_W_DEF,
  parameter int SCORE_MAX    = SCORE_MAX_DEF,
  parameter int PTS_PER_KILL = 10,
  parameter int CLEAR_BONUS  = 50,
  parameter int BCD_DIGITS   = BCD_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    game_start,
  input  logic [N_ENEMY-1:0]      enemy_killed,
  output logic [SCORE_W-1:0]      score,
  output logic [SCORE_W-1:0]      high_score,
  output logic                    new_high,
  output logic                    all_clear,
  output logic [4*BCD_DIGITS-1:0] score_bcd,
  output logic                    bcd_valid
);
  localparam int PW = $clog2(N_ENEMY + 1);

  function automatic logic [PW-1:0] popcount(input logic [N_ENEMY-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N_ENEMY; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  logic [N_ENEMY-1:0] killed_q, new_kill;
  logic               wave, score_chg, dirty, cvt_idle, cvt_done, cvt_start;
  logic [SCORE_W:0]   delta, sum;
  logic [SCORE_W-1:0] score_nxt;

  assign new_kill = enemy_killed & ~killed_q;
  assign wave     = (&enemy_killed) & ~(&killed_q);
  assign delta    = (SCORE_W+1)'(int'(popcount(new_kill)) * PTS_PER_KILL +
                                 (wave ? CLEAR_BONUS : 0));
  assign sum      = {1'b0, score} + delta;

  always_comb begin
    score_nxt = sum[SCORE_W-1:0];
    if (game_start)
      score_nxt = '0;
    else if (sum > (SCORE_W+1)'(SCORE_MAX))
      score_nxt = SCORE_W'(SCORE_MAX);
  end

  assign score_chg = (score_nxt != score);
  assign cvt_start = dirty & cvt_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      score      <= '0;
      high_score <= '0;
      killed_q   <= '0;
      new_high   <= 1'b0;
      all_clear  <= 1'b0;
      dirty      <= 1'b0;
      bcd_valid  <= 1'b1;
    end else begin
      killed_q  <= enemy_killed;
      score     <= score_nxt;
      all_clear <= wave & ~game_start;
      if (score > high_score) high_score <= score;
      if (game_start)                new_high <= 1'b0;
      else if (score > high_score)   new_high <= 1'b1;
      // A change during conversion re-arms dirty so the final value is always converted.
      if (score_chg)      dirty <= 1'b1;
      else if (cvt_start) dirty <= 1'b0;
      if (score_chg)                bcd_valid <= 1'b0;
      else if (cvt_done && !dirty)  bcd_valid <= 1'b1;
    end
  end

  score_bin2bcd #(.W(SCORE_W), .DIGITS(BCD_DIGITS)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cvt_start),
    .value (score),
    .idle  (cvt_idle),
    .done  (cvt_done),
    .bcd   (score_bcd)
  );
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares.
module tb_score_keeper;
  logic        clk = 1'b0;
  logic        rst, game_start;
  logic [7:0]  enemy_killed;
  logic [13:0] score, high_score;
  logic        new_high, all_clear, bcd_valid;
  logic [15:0] score_bcd;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk(clk), .rst(rst), .game_start(game_start), .enemy_killed(enemy_killed),
    .score(score), .high_score(high_score), .new_high(new_high),
    .all_clear(all_clear), .score_bcd(score_bcd), .bcd_valid(bcd_valid)
  );

  typedef struct {int sc; int hi; bit nh; bit ac;} exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0;
  int m_score = 0, m_high = 0;
  bit m_nh = 0;
  logic [7:0] m_prev = '0;

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  // Drive one cycle of inputs and push what the outputs must be after the next edge.
  task automatic step(input bit gs, input logic [7:0] ek);
    exp_t e;
    int n;
    bit wv;
    @(negedge clk);
    game_start   = gs;
    enemy_killed = ek;
    if (m_score > m_high) begin
      m_high = m_score;
      m_nh   = 1;
    end
    if (gs) m_nh = 0;
    n = 0;
    for (int i = 0; i < 8; i++) if (ek[i] && !m_prev[i]) n++;
    wv = (ek == 8'hFF) && (m_prev != 8'hFF);
    if (gs) begin
      m_score = 0;
      e.ac    = 0;
    end else begin
      m_score = m_score + n * 10 + (wv ? 50 : 0);
      if (m_score > 9999) m_score = 9999;
      e.ac = wv;
    end
    m_prev = ek;
    e.sc = m_score; e.hi = m_high; e.nh = m_nh;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("score", int'(score), e.sc);
        chk("high_score", int'(high_score), e.hi);
        chk("new_high", int'(new_high), int'(e.nh));
        chk("all_clear", int'(all_clear), int'(e.ac));
        if (bcd_valid) chk("score_bcd", int'(score_bcd), to_bcd(e.sc));
      end
    end
  end

  initial begin
    logic [7:0] cur;
    int w;
    rst = 1'b1; game_start = 1'b0; enemy_killed = '0;
    repeat (3) @(negedge clk);
    chk("rst_score", int'(score), 0);
    chk("rst_bcd_valid", int'(bcd_valid), 1);
    rst = 1'b0;

    repeat (20) step(0, 8'h00);
    chk("idle_score", int'(score), 0);
    chk("idle_high", int'(high_score), 0);
    chk("idle_bcd", int'(score_bcd), 0);
    chk("idle_bcd_valid", int'(bcd_valid), 1);
    chk("idle_all_clear", int'(all_clear), 0);

    // First kill: BCD becomes valid exactly 16 edges after the score edge.
    step(0, 8'h01);
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk);
      #1;
      chk("bcd_latency", int'(bcd_valid), (k == 16) ? 1 : 0);
      if (k == 16) chk("bcd_10", int'(score_bcd), 16'h0010);
      step(0, 8'h01);
    end
    repeat (5) step(0, 8'h01);
    chk("held_score", int'(score), 10);

    step(0, 8'h07); step(0, 8'h07);
    chk("score_30", int'(score), 30);
    step(0, 8'hFF);
    @(posedge clk); #1;
    chk("clear_pulse", int'(all_clear), 1);
    chk("score_130", int'(score), 130);
    step(0, 8'hFF); step(0, 8'hFF);
    chk("clear_once", int'(all_clear), 0);

    step(1, 8'hFF); step(0, 8'hFF);
    step(0, 8'h00); step(0, 8'h0F); step(0, 8'h0F);
    chk("new_game_score", int'(score), 40);
    chk("kept_high", int'(high_score), 130);
    chk("new_high_clr", int'(new_high), 0);
    step(0, 8'hFF); step(0, 8'hFE); step(0, 8'hFF);
    repeat (3) step(0, 8'hFF);
    chk("respawn_score", int'(score), 190);
    chk("raised_high", int'(high_score), 190);
    chk("new_high_set", int'(new_high), 1);

    cur = 8'hFF;
    repeat (400) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 50)      cur = cur ^ (8'h01 << $urandom_range(0, 7));
      else if (r < 70) cur = 8'hFF;
      else if (r < 80) cur = 8'h00;
      else             cur = 8'($urandom);
      step(r < 3, cur);
    end

    while (m_score < 9800) begin
      step(0, 8'h00);
      step(0, 8'hFF);
    end
    repeat (3) begin step(0, 8'h00); step(0, 8'hFF); end
    step(0, 8'hFF);
    chk("saturated", int'(score), 9999);

    w = 0;
    while (!bcd_valid && w < 40) begin
      step(0, 8'hFF);
      w++;
    end
    chk("bcd_valid_final", int'(bcd_valid), 1);
    chk("bcd_9999", int'(score_bcd), 16'h9999);
    repeat (2) step(0, 8'hFF);
    @(posedge clk); #2;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
